// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: double-buffered BCD frame,
// dead-time blanking between digits and optional leading-zero suppression.
module seven_seg_scan_ctrl #(
    parameter int          N_DIGITS     = 4,
    parameter int          REFRESH_DIV  = 100000,
    parameter int          BLANK_CYCLES = 1000,
    parameter logic [3:0]  BLANK_CODE   = 4'hF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    lz_en,
    output logic                    load_ack,
    output logic [3:0]              digit_code,
    output logic [N_DIGITS-1:0]     an_n,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t                      state, state_d;
    logic [IW-1:0]               idx, idx_d;
    logic [CW-1:0]               cnt, cnt_d;
    logic [N_DIGITS-1:0][3:0]    pend, pend_d, act, act_d;
    logic [N_DIGITS-1:0]         pend_dp, pend_dp_d, act_dp, act_dp_d;
    logic [N_DIGITS-1:0]         supp;
    logic                        wrap, xfer, allz;
    logic [N_DIGITS-1:0]         an_d;
    logic [3:0]                  code_d;
    logic                        dp_d, fd_d;

    // Digit i (>0) is blank when it and every digit above it is zero.
    always_comb begin
        supp = '0;
        allz = lz_en;
        for (int unsigned i = N_DIGITS - 1; i >= 1; i--) begin
            allz    = allz && (act[i] == 4'd0);
            supp[i] = allz;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        wrap    = 1'b0;
        fd_d    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_d = BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            BLANK: begin
                if (cnt == CW'(BLANK_CYCLES - 1)) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            SHOW: begin
                if (cnt == CW'(REFRESH_DIV - 1)) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (idx == IW'(N_DIGITS - 1)) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                        fd_d  = 1'b1;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            wrap    = 1'b0;
            fd_d    = 1'b0;
        end
    end

    // A load on the transfer edge bypasses pending and lands in active directly.
    always_comb begin
        xfer      = wrap || (state == IDLE);
        pend_d    = load ? digits_in : pend;
        pend_dp_d = load ? dp_in : pend_dp;
        act_d     = xfer ? pend_d : act;
        act_dp_d  = xfer ? pend_dp_d : act_dp;
    end

    // SHOW is only entered from BLANK, never on a transfer edge, so the current active frame is the right source.
    always_comb begin
        an_d   = '1;
        code_d = BLANK_CODE;
        dp_d   = 1'b1;
        if (state_d == SHOW) begin
            an_d[idx_d] = 1'b0;
            code_d      = supp[idx_d] ? BLANK_CODE : act[idx_d];
            dp_d        = ~act_dp[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            pend       <= {N_DIGITS{BLANK_CODE}};
            act        <= {N_DIGITS{BLANK_CODE}};
            pend_dp    <= '0;
            act_dp     <= '0;
            an_n       <= '1;
            digit_code <= BLANK_CODE;
            dp_n       <= 1'b1;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            cnt        <= cnt_d;
            pend       <= pend_d;
            act        <= act_d;
            pend_dp    <= pend_dp_d;
            act_dp     <= act_dp_d;
            an_n       <= an_d;
            digit_code <= code_d;
            dp_n       <= dp_d;
            load_ack   <= load;
            frame_done <= fd_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic        load_ack;
    logic [3:0]  digit_code;
    logic [3:0]  an_n;
    logic        dp_n;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;

    seven_seg_scan_ctrl #(
        .N_DIGITS     (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2),
        .BLANK_CODE   (4'hF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .load_ack   (load_ack),
        .digit_code (digit_code),
        .an_n       (an_n),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        assert ($countones(~an_n) <= 1) else begin
            miscompares++;
            $error("FAIL onehot_an: got %b expected at most one low bit", an_n);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the negedge where frame_done is high.
    task automatic wait_fd();
        int n;
        n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_frame_done", {31'd0, frame_done}, 32'd1);
    endtask

    // k=0 is the frame_done cycle; each digit takes 2 blank + 8 lit cycles.
    task automatic check_frame(input int start_k, input logic [15:0] exp_codes, input logic [3:0] exp_dp);
        int g, p;
        logic [3:0] e_an, e_code;
        logic e_dp;
        for (int k = start_k; k < 40; k++) begin
            g = k / 10;
            p = k % 10;
            if (p < 2) begin
                e_an = 4'hF; e_code = 4'hF; e_dp = 1'b1;
            end else begin
                e_an   = ~(4'b0001 << g);
                e_code = exp_codes[4*g +: 4];
                e_dp   = ~exp_dp[g];
            end
            chk($sformatf("an_n[k=%0d]", k), {28'd0, an_n}, {28'd0, e_an});
            chk($sformatf("code[k=%0d]", k), {28'd0, digit_code}, {28'd0, e_code});
            chk($sformatf("dp_n[k=%0d]", k), {31'd0, dp_n}, {31'd0, e_dp});
            chk($sformatf("fd[k=%0d]", k), {31'd0, frame_done}, {31'd0, (k == 0)});
            @(negedge clk);
        end
        chk("fd_period", {31'd0, frame_done}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; load = 1'b0;
        digits_in = 16'h0000; dp_in = 4'b0000; lz_en = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_an", {28'd0, an_n}, 32'hF);
        chk("rst_code", {28'd0, digit_code}, 32'hF);
        chk("rst_dp", {31'd0, dp_n}, 32'd1);
        chk("rst_ack", {31'd0, load_ack}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;

        // Scenario 1: enable and load 1234 together
        @(negedge clk);
        enable = 1'b1; load = 1'b1; digits_in = 16'h1234;
        @(negedge clk);
        load = 1'b0;
        chk("s1_ack_hi", {31'd0, load_ack}, 32'd1);
        @(negedge clk);
        chk("s1_ack_lo", {31'd0, load_ack}, 32'd0);
        wait_fd();
        check_frame(0, 16'h1234, 4'b0000);

        // Scenario 2: back-to-back loads, last wins; leading-zero suppression
        lz_en = 1'b1; load = 1'b1; digits_in = 16'h7777;
        @(negedge clk);
        digits_in = 16'h0050;
        chk("s2_ack1", {31'd0, load_ack}, 32'd1);
        @(negedge clk);
        load = 1'b0;
        chk("s2_ack2", {31'd0, load_ack}, 32'd1);
        @(negedge clk);
        chk("s2_ack_lo", {31'd0, load_ack}, 32'd0);
        wait_fd();
        check_frame(0, 16'hFF50, 4'b0000);
        lz_en = 1'b0;
        check_frame(0, 16'h0050, 4'b0000);

        // Scenario 3: load 9999 while digit 1 is lit
        repeat (14) @(negedge clk);
        chk("s3_ack_pre", {31'd0, load_ack}, 32'd0);
        load = 1'b1; digits_in = 16'h9999;
        @(negedge clk);
        load = 1'b0;
        chk("s3_ack_hi", {31'd0, load_ack}, 32'd1);
        @(negedge clk);
        chk("s3_ack_lo", {31'd0, load_ack}, 32'd0);
        check_frame(16, 16'h0050, 4'b0000);
        check_frame(0, 16'h9999, 4'b0000);

        // Scenario 4: load exactly on the wrap edge bypasses into active
        repeat (39) @(negedge clk);
        load = 1'b1; digits_in = 16'h5678;
        @(negedge clk);
        load = 1'b0;
        chk("s4_ack", {31'd0, load_ack}, 32'd1);
        check_frame(0, 16'h5678, 4'b0000);

        // Scenario 7: decimal point on digit 2 only
        load = 1'b1; dp_in = 4'b0100;
        @(negedge clk);
        load = 1'b0;
        wait_fd();
        check_frame(0, 16'h5678, 4'b0100);

        // Scenario 5: drop enable while digit 2 is lit
        repeat (24) @(negedge clk);
        chk("s5_pre_an", {28'd0, an_n}, 32'hB);
        enable = 1'b0;
        @(negedge clk);
        chk("s5_an", {28'd0, an_n}, 32'hF);
        chk("s5_code", {28'd0, digit_code}, 32'hF);
        chk("s5_dp", {31'd0, dp_n}, 32'd1);
        chk("s5_fd", {31'd0, frame_done}, 32'd0);
        repeat (3) @(negedge clk);
        chk("s5_idle_an", {28'd0, an_n}, 32'hF);
        enable = 1'b1;
        @(negedge clk);
        chk("s5_blank0", {28'd0, an_n}, 32'hF);
        @(negedge clk);
        chk("s5_blank1", {28'd0, an_n}, 32'hF);
        @(negedge clk);
        chk("s5_show0_an", {28'd0, an_n}, 32'hE);
        chk("s5_show0_code", {28'd0, digit_code}, 32'h8);
        chk("s5_show0_dp", {31'd0, dp_n}, 32'd1);

        // Scenario 6: asynchronous reset while digit 2 (with dp) is lit
        repeat (20) @(negedge clk);
        chk("s6_pre_an", {28'd0, an_n}, 32'hB);
        chk("s6_pre_dp", {31'd0, dp_n}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_an", {28'd0, an_n}, 32'hF);
        chk("s6_dp", {31'd0, dp_n}, 32'd1);
        chk("s6_code", {28'd0, digit_code}, 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("s6_blank0", {28'd0, an_n}, 32'hF);
        @(negedge clk);
        @(negedge clk);
        chk("s6_show0_an", {28'd0, an_n}, 32'hE);
        chk("s6_show0_code", {28'd0, digit_code}, 32'hF);
        chk("s6_show0_dp", {31'd0, dp_n}, 32'd1);
        wait_fd();
        check_frame(0, 16'hFFFF, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
